result_writer: RTL and testbench

- Downstream of the sparse-row multiply-accumulate stage.
- Captures each finished row sum (push/dout) into a local FIFO and streams the sums to memory as sequential 64-bit write requests (base_addr + 8*index), with a stall handshake.
- The MAC stage has no backpressure, so this block absorbs bursts, flags overflow, and signals completion once the expected number of results has been written.

---
 rtl/result_writer_pkg.sv | 14 +
 rtl/result_writer_if.sv | 26 ++
 rtl/result_writer_fifo.sv | 48 ++++
 rtl/result_writer.sv | 116 +++++++++++
 tb/tb_result_writer.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/result_writer_pkg.sv
// Shared types and constants for the result writer: FSM states, word width,
// and the per-result address stride.
package result_writer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FIN
  } state_t;

  localparam int DATA_W   = 64;
  localparam int ADDR_INC = 8;

endpackage

// File: rtl/result_writer_if.sv
// Memory write-request channel: registered request/address/data with a stall
// back from memory.
interface result_writer_if #(
  parameter int ADDR_W = 48
) ();

  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [63:0]       mem_data;
  logic              mem_stall;

  modport master (
    output mem_req,
    output mem_addr,
    output mem_data,
    input  mem_stall
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    input  mem_data,
    output mem_stall
  );

endinterface

// File: rtl/result_writer_fifo.sv
// Synchronous show-ahead FIFO buffering row sums; a write while full succeeds
// only when a read frees a slot in the same cycle.
module result_fifo #(
  parameter int DEPTH_LOG2 = 6,
  parameter int WIDTH      = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr,
  input  logic [WIDTH-1:0] din,
  input  logic             rd,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]    store [DEPTH];
  logic [DEPTH_LOG2:0] wptr;
  logic [DEPTH_LOG2:0] rptr;
  logic                do_rd;
  logic                do_wr;

  assign empty = (wptr == rptr);
  assign full  = (wptr[DEPTH_LOG2] != rptr[DEPTH_LOG2]) &&
                 (wptr[DEPTH_LOG2-1:0] == rptr[DEPTH_LOG2-1:0]);
  assign dout  = store[rptr[DEPTH_LOG2-1:0]];

  // Reads gate on empty, so a write into an empty FIFO is never bypassed.
  assign do_rd = rd && !empty;
  assign do_wr = wr && (!full || do_rd);

  always_ff @(posedge clk) begin
    if (do_wr) store[wptr[DEPTH_LOG2-1:0]] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_wr) wptr <= wptr + 1'b1;
      if (do_rd) rptr <= rptr + 1'b1;
    end
  end

endmodule

// File: rtl/result_writer.sv
// Buffers MAC row sums and streams them to memory as sequential 64-bit writes,
// tracking the count, overflow and completion of each run.
module result_writer
  import result_writer_pkg::*;
#(
  parameter int FIFO_DEPTH_LOG2 = 6,
  parameter int ADDR_W          = 48,
  parameter int CNT_W           = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  expected_count,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  result_writer_if.master   mem,
  output logic              busy,
  output logic              finished,
  output logic              overflow,
  output logic [CNT_W-1:0]  written_count
);

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  exp_cnt;
  logic [ADDR_W-1:0] addr_nxt;
  logic              req_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;

  logic [DATA_W-1:0] f_dout;
  logic              f_full;
  logic              f_empty;

  logic              start_acc;
  logic              accept;
  logic              out_free;
  logic              load;
  logic [CNT_W:0]    issued;

  result_fifo #(
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2),
    .WIDTH      (DATA_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .wr    (push),
    .din   (din),
    .rd    (load),
    .dout  (f_dout),
    .full  (f_full),
    .empty (f_empty)
  );

  assign start_acc = start && (state == ST_IDLE);
  assign accept    = req_q && !mem.mem_stall;
  assign out_free  = !req_q || !mem.mem_stall;

  // Results already handed out = accepted ones plus the one in the register.
  assign issued = {1'b0, written_count} + {{CNT_W{1'b0}}, req_q};
  assign load   = out_free && (state == ST_RUN) && !f_empty &&
                  (issued < {1'b0, exp_cnt});

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = (expected_count == '0) ? ST_FIN : ST_RUN;
      ST_RUN:  if (accept && ((written_count + 1'b1) == exp_cnt)) state_nxt = ST_FIN;
      ST_FIN:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      exp_cnt       <= '0;
      addr_nxt      <= '0;
      written_count <= '0;
      overflow      <= 1'b0;
      req_q         <= 1'b0;
      addr_q        <= '0;
      data_q        <= '0;
    end else begin
      state <= state_nxt;

      if (start_acc) begin
        exp_cnt       <= expected_count;
        addr_nxt      <= base_addr;
        written_count <= '0;
      end else if (accept) begin
        written_count <= written_count + 1'b1;
      end

      if (push && f_full && !load) overflow <= 1'b1;
      else if (start_acc)          overflow <= 1'b0;

      if (load) begin
        req_q    <= 1'b1;
        addr_q   <= addr_nxt;
        data_q   <= f_dout;
        addr_nxt <= addr_nxt + ADDR_W'(ADDR_INC);
      end else if (out_free) begin
        req_q <= 1'b0;
      end
    end
  end

  assign mem.mem_req  = req_q;
  assign mem.mem_addr = addr_q;
  assign mem.mem_data = data_q;
  assign busy         = (state == ST_RUN);
  assign finished     = (state == ST_FIN);

endmodule

// File: tb/tb_result_writer.sv
// Scoreboard bench for result_writer: expected writes queued at stimulus time,
// checked against each accepted memory request.
module tb_result_writer;

  localparam int ADDR_W = 48;
  localparam int CNT_W  = 32;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [63:0]       data;
  } sb_t;

  logic              clk;
  logic              reset;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [CNT_W-1:0]  expected_count;
  logic              push;
  logic [63:0]       din;
  logic              busy;
  logic              finished;
  logic              overflow;
  logic [CNT_W-1:0]  written_count;

  int n_tests = 0;
  int n_fail  = 0;
  sb_t sb_q[$];

  result_writer_if #(.ADDR_W(ADDR_W)) mem_if ();

  result_writer #(
    .FIFO_DEPTH_LOG2 (6),
    .ADDR_W          (ADDR_W),
    .CNT_W           (CNT_W)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .base_addr      (base_addr),
    .expected_count (expected_count),
    .push           (push),
    .din            (din),
    .mem            (mem_if),
    .busy           (busy),
    .finished       (finished),
    .overflow       (overflow),
    .written_count  (written_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_wr(input logic [ADDR_W-1:0] addr, input logic [63:0] data);
    sb_t e;
    e.addr = addr;
    e.data = data;
    sb_q.push_back(e);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    push  = 1'b0;
    mem_if.mem_stall = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic do_start(input logic [ADDR_W-1:0] base, input logic [CNT_W-1:0] cnt);
    base_addr      = base;
    expected_count = cnt;
    start          = 1'b1;
    tick();
    start          = 1'b0;
  endtask

  task automatic wait_finished(input int budget, input logic [CNT_W-1:0] cnt);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (finished) break;
    end
    check("fin_seen", finished, 1);
    check("wr_count", written_count, cnt);
    check("busy_in_fin", busy, 0);
    @(negedge clk);
    check("fin_pulse", finished, 0);
    check("sb_drained", sb_q.size(), 0);
    sb_q.delete();
  endtask

  // Every accepted request is matched against the oldest expected write.
  always @(negedge clk) begin : monitor
    sb_t e;
    if (!reset && mem_if.mem_req && !mem_if.mem_stall) begin
      if (sb_q.size() == 0) begin
        check("unexpected_req", mem_if.mem_req, 0);
      end else begin
        e = sb_q.pop_front();
        check("req_addr", mem_if.mem_addr, e.addr);
        check("req_data", mem_if.mem_data, e.data);
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    base_addr      = '0;
    expected_count = '0;
    din            = '0;
    reset          = 1'b1;
    start          = 1'b0;
    push           = 1'b0;
    mem_if.mem_stall = 1'b0;

    // Reset state
    do_reset();
    reset = 1'b1;
    @(negedge clk);
    check("rst_req", mem_if.mem_req, 0);
    check("rst_busy", busy, 0);
    check("rst_fin", finished, 0);
    check("rst_ovf", overflow, 0);
    check("rst_cnt", written_count, 0);
    tick();
    reset = 1'b0;

    // Basic run with latency checks
    do_start(48'h1000, 3);
    @(negedge clk);
    check("busy_run", busy, 1);
    push = 1'b1; din = 64'hA; expect_wr(48'h1000, 64'hA);
    tick();
    din = 64'hB; expect_wr(48'h1008, 64'hB);
    @(negedge clk);
    check("lat_not_yet", mem_if.mem_req, 0);
    tick();
    din = 64'hC; expect_wr(48'h1010, 64'hC);
    @(negedge clk);
    check("lat_first_req", mem_if.mem_req, 1);
    tick();
    push = 1'b0;
    wait_finished(20, 3);

    // Stall hold on the second request
    do_start(48'h1000, 3);
    push = 1'b1; din = 64'hA; expect_wr(48'h1000, 64'hA);
    tick();
    din = 64'hB; expect_wr(48'h1008, 64'hB);
    tick();
    din = 64'hC; expect_wr(48'h1010, 64'hC);
    tick();
    push = 1'b0;
    mem_if.mem_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("stall_req", mem_if.mem_req, 1);
      check("stall_addr", mem_if.mem_addr, 48'h1008);
      check("stall_data", mem_if.mem_data, 64'hB);
      tick();
    end
    mem_if.mem_stall = 1'b0;
    wait_finished(20, 3);

    // Overflow under permanent stall, then drain
    mem_if.mem_stall = 1'b1;
    do_start(48'h4000, 65);
    for (int i = 0; i < 66; i++) begin
      push = 1'b1;
      din  = 64'h100 + 64'(i);
      if (i < 65) expect_wr(48'h4000 + 48'(8 * i), 64'h100 + 64'(i));
      if (i == 65) begin
        @(negedge clk);
        check("ovf_before", overflow, 0);
      end
      tick();
    end
    push = 1'b0;
    @(negedge clk);
    check("ovf_set", overflow, 1);
    tick();
    tick();
    @(negedge clk);
    check("ovf_sticky", overflow, 1);
    mem_if.mem_stall = 1'b0;
    wait_finished(200, 65);
    check("ovf_after_drain", overflow, 1);

    // Zero count: next start also clears overflow
    do_start(48'h5000, 0);
    @(negedge clk);
    check("zero_fin", finished, 1);
    check("zero_ovf_clr", overflow, 0);
    check("zero_req", mem_if.mem_req, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("zero_no_req", mem_if.mem_req, 0);
      tick();
    end

    // Reset mid-run with queued data and overflow set
    mem_if.mem_stall = 1'b1;
    do_start(48'h6000, 10);
    for (int i = 0; i < 70; i++) begin
      push = 1'b1;
      din  = 64'hDEAD_0000 + 64'(i);
      tick();
    end
    push = 1'b0;
    @(negedge clk);
    check("pre_rst_ovf", overflow, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    mem_if.mem_stall = 1'b0;
    @(negedge clk);
    check("mid_rst_req", mem_if.mem_req, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ovf", overflow, 0);
    do_start(48'h3000, 2);
    push = 1'b1; din = 64'h55; expect_wr(48'h3000, 64'h55);
    tick();
    din = 64'h66; expect_wr(48'h3008, 64'h66);
    tick();
    push = 1'b0;
    wait_finished(20, 2);

    // Address wrap; the surplus third entry carries over to the next run
    do_start(48'hFFFF_FFFF_FFF8, 2);
    push = 1'b1; din = 64'h1111; expect_wr(48'hFFFF_FFFF_FFF8, 64'h1111);
    tick();
    din = 64'h2222; expect_wr(48'h0, 64'h2222);
    tick();
    din = 64'h3333;
    tick();
    push = 1'b0;
    wait_finished(20, 2);
    expect_wr(48'h7000, 64'h3333);
    do_start(48'h7000, 1);
    wait_finished(20, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
